muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 101 ++++++++++
 tb/tb_muldiv_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit, one radix-2 step per cycle
module muldiv_unit #(
    parameter logic BYPASS_SPECIAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [4:0]  rd_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  rd_out
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_nx;
    logic [2:0]  op_q;
    logic [63:0] acc, acc_nx, prod_fix;
    logic [31:0] mc, amag, bmag, word, res_fin, sp_res;
    logic [32:0] sum, rem_try;
    logic [4:0]  cnt;
    logic        neg, neg_in, a_sg, b_sg, div0, ovf, special, accept, last;

    // Operand preparation at accept: magnitudes, result sign and special-case detection.
    // A zero divisor never negates the quotient so it stays all ones for signed DIV too.
    always_comb begin
        a_sg    = op[2] ? ~op[0] : (op[1:0] != 2'b11);
        b_sg    = op[2] ? ~op[0] : ~op[1];
        amag    = (a_sg && rs1[31]) ? -rs1 : rs1;
        bmag    = (b_sg && rs2[31]) ? -rs2 : rs2;
        div0    = op[2] && (rs2 == 32'd0);
        ovf     = op[2] && !op[0] && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
        special = div0 || ovf;
        neg_in  = op[2] ? (op[1] ? (a_sg & rs1[31]) : (a_sg & (rs1[31] ^ rs2[31]) & ~div0))
                        : ((a_sg & rs1[31]) ^ (b_sg & rs2[31]));
        sp_res  = op[1] ? (div0 ? rs1 : 32'd0) : (div0 ? 32'hFFFF_FFFF : 32'h8000_0000);
    end

    // One iteration: shift-add multiply in {hi,lo}, restoring divide with {rem,quot}.
    always_comb begin
        sum      = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mc} : 33'd0);
        rem_try  = acc[63:31] - {1'b0, mc};
        acc_nx   = op_q[2] ? (rem_try[32] ? {acc[62:0], 1'b0} : {rem_try[31:0], acc[30:0], 1'b1})
                           : {sum, acc[31:1]};
        prod_fix = neg ? -acc_nx : acc_nx;
        word     = op_q[1] ? acc_nx[63:32] : acc_nx[31:0];
        res_fin  = op_q[2] ? (neg ? -word : word)
                           : ((op_q[1:0] == 2'b00) ? prod_fix[31:0] : prod_fix[63:32]);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next state and status outputs.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        last     = (state == CALC) && (cnt == 5'd31);
        busy     = (state != IDLE);
        done     = (state == DONE);
        case (state)
            IDLE: if (start) begin
                accept   = 1'b1;
                state_nx = (BYPASS_SPECIAL && special) ? DONE : CALC;
            end
            CALC: state_nx = last ? DONE : CALC;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, iterate in CALC, register the result into DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q   <= 3'd0;
            acc    <= 64'd0;
            mc     <= 32'd0;
            neg    <= 1'b0;
            cnt    <= 5'd0;
            result <= 32'd0;
            rd_out <= 5'd0;
        end else if (accept) begin
            op_q   <= op;
            acc    <= {32'd0, amag};
            mc     <= bmag;
            neg    <= neg_in;
            cnt    <= 5'd0;
            rd_out <= rd_in;
            if (BYPASS_SPECIAL && special) result <= sp_res;
        end else if (state == CALC) begin
            acc <= acc_nx;
            cnt <= cnt + 5'd1;
            if (last) result <= res_fin;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for the iterative mul/div unit
module tb_muldiv_unit;
    logic        clk, rst, start;
    logic [2:0]  op;
    logic [31:0] rs1, rs2;
    logic [4:0]  rd_in;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    int          checks, failures;

    muldiv_unit #(.BYPASS_SPECIAL(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
        .rd_in(rd_in), .busy(busy), .done(done), .result(result), .rd_out(rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request and wait (bounded) for done; lat=0 means it never came.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int lat, output logic [31:0] res,
                         output logic [4:0] rdo);
        @(negedge clk);
        start = 1'b1; op = o; rs1 = a; rs2 = b; rd_in = rd;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        res = result;
        rdo = rd_out;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #1;
        checks += 4;
        if (busy !== 1'b0)    begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0)    begin failures++; $display("FAIL reset_done got %b want 0", done); end
        if (result !== 32'd0) begin failures++; $display("FAIL reset_result got %h want 0", result); end
        if (rd_out !== 5'd0)  begin failures++; $display("FAIL reset_rd got %h want 0", rd_out); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_mul;
        int lat; logic [31:0] res; logic [4:0] rdo;
        do_op(3'd0, 32'd7, 32'd6, 5'd5, lat, res, rdo);
        checks += 5;
        if (lat !== 33)          begin failures++; $display("FAIL mul_latency got %0d want 33", lat); end
        if (res !== 32'h2A)      begin failures++; $display("FAIL mul_7x6 got %h want 0000002a", res); end
        if (rdo !== 5'd5)        begin failures++; $display("FAIL mul_rd got %0d want 5", rdo); end
        if (busy !== 1'b1)       begin failures++; $display("FAIL busy_in_done got %b want 1", busy); end
        @(negedge clk);
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL after_done got done=%b busy=%b want 0 0", done, busy);
        end
        do_op(3'd0, 32'hFFFF_FFFD, 32'd5, 5'd1, lat, res, rdo);
        checks++;
        if (res !== 32'hFFFF_FFF1) begin failures++; $display("FAIL mul_neg got %h want fffffff1", res); end
    endtask

    task automatic test_mulh;
        int lat; logic [31:0] res; logic [4:0] rdo;
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2, lat, res, rdo);
        checks++;
        if (res !== 32'h4000_0000) begin failures++; $display("FAIL mulh_min got %h want 40000000", res); end
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, lat, res, rdo);
        checks++;
        if (res !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mulhu got %h want fffffffe", res); end
        do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd4, lat, res, rdo);
        checks++;
        if (res !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mulhsu got %h want ffffffff", res); end
        do_op(3'd1, 32'hFFFF_FFFF, 32'd1, 5'd4, lat, res, rdo);
        checks++;
        if (res !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mulh_neg1 got %h want ffffffff", res); end
    endtask

    task automatic test_div;
        int lat; logic [31:0] res; logic [4:0] rdo;
        do_op(3'd5, 32'd100, 32'd7, 5'd6, lat, res, rdo);
        checks += 2;
        if (res !== 32'd14) begin failures++; $display("FAIL divu got %h want 0000000e", res); end
        if (lat !== 33)     begin failures++; $display("FAIL div_latency got %0d want 33", lat); end
        do_op(3'd7, 32'd100, 32'd7, 5'd6, lat, res, rdo);
        checks++;
        if (res !== 32'd2) begin failures++; $display("FAIL remu got %h want 00000002", res); end
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, lat, res, rdo);
        checks++;
        if (res !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_neg got %h want fffffffd", res); end
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7, lat, res, rdo);
        checks++;
        if (res !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rem_neg got %h want ffffffff", res); end
        do_op(3'd4, 32'd7, 32'hFFFF_FFFE, 5'd8, lat, res, rdo);
        checks++;
        if (res !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_negdiv got %h want fffffffd", res); end
        do_op(3'd6, 32'd7, 32'hFFFF_FFFE, 5'd8, lat, res, rdo);
        checks++;
        if (res !== 32'd1) begin failures++; $display("FAIL rem_negdiv got %h want 00000001", res); end
    endtask

    task automatic test_special;
        int lat; logic [31:0] res; logic [4:0] rdo;
        do_op(3'd4, 32'd5, 32'd0, 5'd9, lat, res, rdo);
        checks += 3;
        if (lat !== 1)             begin failures++; $display("FAIL div0_latency got %0d want 1", lat); end
        if (res !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div0 got %h want ffffffff", res); end
        if (rdo !== 5'd9)          begin failures++; $display("FAIL div0_rd got %0d want 9", rdo); end
        do_op(3'd6, 32'd5, 32'd0, 5'd9, lat, res, rdo);
        checks++;
        if (res !== 32'd5) begin failures++; $display("FAIL rem0 got %h want 00000005", res); end
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, lat, res, rdo);
        checks += 2;
        if (res !== 32'h8000_0000) begin failures++; $display("FAIL div_ovf got %h want 80000000", res); end
        if (lat !== 1)             begin failures++; $display("FAIL ovf_latency got %0d want 1", lat); end
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, lat, res, rdo);
        checks++;
        if (res !== 32'd0) begin failures++; $display("FAIL rem_ovf got %h want 00000000", res); end
        do_op(3'd4, 32'hFFFF_FFFB, 32'd0, 5'd11, lat, res, rdo);
        checks++;
        if (res !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div0_neg got %h want ffffffff", res); end
        do_op(3'd7, 32'hFFFF_FFFB, 32'd0, 5'd11, lat, res, rdo);
        checks++;
        if (res !== 32'hFFFF_FFFB) begin failures++; $display("FAIL remu0 got %h want fffffffb", res); end
        do_op(3'd5, 32'd5, 32'd0, 5'd11, lat, res, rdo);
        checks++;
        if (res !== 32'hFFFF_FFFF) begin failures++; $display("FAIL divu0 got %h want ffffffff", res); end
    endtask

    task automatic test_ignore_start;
        int first, pulses; logic busy34; logic [31:0] res40;
        @(negedge clk);
        start = 1'b1; op = 3'd0; rs1 = 32'd7; rs2 = 32'd6; rd_in = 5'd3;
        @(negedge clk);
        start = 1'b0;
        first = 0; pulses = 0; busy34 = 1'bx; res40 = 32'hx;
        for (int k = 1; k <= 45; k++) begin
            if (done) begin
                pulses++;
                if (first == 0) first = k;
            end
            if (k == 34) busy34 = busy;
            if (k == 40) res40 = result;
            start = (k == 10 || k == 33);
            op = 3'd0; rs1 = 32'd2; rs2 = 32'd2; rd_in = 5'd9;
            @(negedge clk);
        end
        start = 1'b0;
        checks += 5;
        if (first !== 33)       begin failures++; $display("FAIL ignore_latency got %0d want 33", first); end
        if (pulses !== 1)       begin failures++; $display("FAIL ignore_pulses got %0d want 1", pulses); end
        if (res40 !== 32'h2A)   begin failures++; $display("FAIL ignore_result got %h want 0000002a", res40); end
        if (rd_out !== 5'd3)    begin failures++; $display("FAIL ignore_rd got %0d want 3", rd_out); end
        if (busy34 !== 1'b0)    begin failures++; $display("FAIL start_in_done got busy=%b want 0", busy34); end
    endtask

    task automatic test_reset_mid;
        int pulses, lat; logic busy14; logic [31:0] res; logic [4:0] rdo;
        @(negedge clk);
        start = 1'b1; op = 3'd0; rs1 = 32'd7; rs2 = 32'd6; rd_in = 5'd12;
        @(negedge clk);
        start = 1'b0;
        pulses = 0; busy14 = 1'bx;
        for (int k = 1; k <= 15; k++) begin
            if (k == 14) busy14 = busy;
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        checks += 5;
        if (busy14 !== 1'b1)  begin failures++; $display("FAIL mid_busy_pre got %b want 1", busy14); end
        if (busy !== 1'b0)    begin failures++; $display("FAIL mid_busy got %b want 0", busy); end
        if (done !== 1'b0)    begin failures++; $display("FAIL mid_done got %b want 0", done); end
        if (result !== 32'd0) begin failures++; $display("FAIL mid_result got %h want 0", result); end
        if (rd_out !== 5'd0)  begin failures++; $display("FAIL mid_rd got %0d want 0", rd_out); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        checks++;
        if (pulses !== 0) begin failures++; $display("FAIL mid_no_done got %0d want 0", pulses); end
        do_op(3'd0, 32'd3, 32'd3, 5'd13, lat, res, rdo);
        checks += 2;
        if (res !== 32'd9) begin failures++; $display("FAIL post_reset_mul got %h want 00000009", res); end
        if (lat !== 33)    begin failures++; $display("FAIL post_reset_lat got %0d want 33", lat); end
    endtask

    task automatic test_back_to_back;
        int lat; logic [31:0] res; logic [4:0] rdo;
        do_op(3'd5, 32'hFFFF_FFFF, 32'd16, 5'd14, lat, res, rdo);
        checks++;
        if (res !== 32'h0FFF_FFFF) begin failures++; $display("FAIL b2b_divu got %h want 0fffffff", res); end
        do_op(3'd3, 32'h0001_0000, 32'h0001_0000, 5'd15, lat, res, rdo);
        checks += 2;
        if (res !== 32'd1)  begin failures++; $display("FAIL b2b_mulhu got %h want 00000001", res); end
        if (rdo !== 5'd15)  begin failures++; $display("FAIL b2b_rd got %0d want 15", rdo); end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; start = 1'b0; op = 3'd0; rs1 = 32'd0; rs2 = 32'd0; rd_in = 5'd0;
        test_reset;
        test_mul;
        test_mulh;
        test_div;
        test_special;
        test_ignore_start;
        test_reset_mid;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
